// File: rtl/divider_pkg.sv
// ============================================================================
// divider_pkg : shared mode and state encodings for the iterative divider
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package divider_pkg;

   localparam logic [1:0] DIV_UNSIGNED = 2'b00;
   localparam logic [1:0] DIV_SIGNED   = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } div_state_t;

endpackage : divider_pkg

`default_nettype wire

// File: rtl/divider.sv
// ============================================================================
// divider : radix-2 restoring divider, one quotient bit per cycle, start/done/stall handshake
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       div_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             start,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             done,
   output logic             stall
);

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shift_w;
   logic             fits_w;
   logic             a_neg_w, b_neg_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         prem_q      <= '0;
         work_q      <= '0;
         dmag_q      <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         work_q      <= work_d;
         dmag_q      <= dmag_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // work_q starts as |dividend| and is shifted out MSB-first while quotient bits fill from the LSB.
   always_comb begin
      shift_w     = {prem_q, work_q[WIDTH-1]};
      fits_w      = (shift_w >= {1'b0, dmag_q});
      a_neg_w     = (div_mode == DIV_SIGNED) && dividend[WIDTH-1];
      b_neg_w     = (div_mode == DIV_SIGNED) && divisor[WIDTH-1];
      cnt_d       = cnt_q;
      prem_d      = prem_q;
      work_d      = work_q;
      dmag_d      = dmag_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d  = CNT_LAST;
               prem_d = '0;
               work_d = a_neg_w ? -dividend : dividend;
               dmag_d = b_neg_w ? -divisor : divisor;
               qneg_d = a_neg_w ^ b_neg_w;
               rneg_d = a_neg_w;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  quotient_d  = '0;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end
            end
         end
         S_CALC: begin
            // Once the wide compare passes, the difference fits in WIDTH bits, so modulo subtraction is exact.
            prem_d = fits_w ? (shift_w[WIDTH-1:0] - dmag_q) : shift_w[WIDTH-1:0];
            work_d = {work_q[WIDTH-2:0], fits_w};
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end
         S_FIX: begin
            quotient_d  = qneg_q ? -work_q : work_q;
            remainder_d = rneg_q ? -prem_q : prem_q;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      done        = (state_q == S_DONE);
      stall       = (state_q == S_CALC) || (state_q == S_FIX);
      quotient    = quotient_q;
      remainder   = remainder_q;
      div_by_zero = dbz_q;
   end

endmodule : divider

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// tb_divider : randomized and directed self-checking bench for divider
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module tb_divider;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    div_mode = 2'b00;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          start = 1'b0;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;
   logic          done;
   logic          stall;

   int checks = 0;
   int errors = 0;

   divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .div_mode(div_mode), .dividend(dividend),
      .divisor(divisor), .start(start), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   // Reference: language-level signed/unsigned division plus the two special cases.
   function automatic void ref_div(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      z = 1'b0;
      if (b == '0) begin
         q = '0; r = a; z = 1'b1;
      end else if (m == 2'b01) begin
         if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a; r = '0;
         end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
         end
      end else begin
         q = a / b; r = a % b;
      end
   endfunction

   // Drives one operation; returns cycles-to-done, stall-high cycles and done one cycle later.
   task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_cyc, output int lat, output int stall_cnt, output logic done_after);
      @(negedge clk);
      div_mode = m; dividend = a; divisor = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; stall_cnt = 0;
      while (done !== 1'b1 && lat < 200) begin
         if (stall === 1'b1) stall_cnt++;
         if (lat == poke_cyc) begin
            start = 1'b1; dividend = 64'd5; divisor = 64'd1; div_mode = 2'b00;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
      checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
      checks++; if ({div_by_zero, done, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {div_by_zero, done, stall}); end
   endtask

   task automatic test_unsigned();
      logic [W-1:0] av [3] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1000};
      logic [W-1:0] bv [3] = '{64'd7, 64'd2, 64'd3};
      logic [W-1:0] qe [3] = '{64'd14, 64'h7FFF_FFFF_FFFF_FFFF, 64'd333};
      logic [W-1:0] re [3] = '{64'd2, 64'd1, 64'd1};
      int lat, sc; logic da;
      for (int i = 0; i < 3; i++) begin
         run_op(2'b00, av[i], bv[i], 0, lat, sc, da);
         checks++; if (quotient !== qe[i]) begin errors++; $display("FAIL unsigned_q[%0d] got %h want %h", i, quotient, qe[i]); end
         checks++; if (remainder !== re[i]) begin errors++; $display("FAIL unsigned_r[%0d] got %h want %h", i, remainder, re[i]); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL unsigned_dbz[%0d] got %b want 0", i, div_by_zero); end
         checks++; if (lat != 66) begin errors++; $display("FAIL unsigned_latency[%0d] got %0d want 66", i, lat); end
         checks++; if (sc != 65) begin errors++; $display("FAIL unsigned_stall[%0d] got %0d want 65", i, sc); end
         checks++; if (da !== 1'b0) begin errors++; $display("FAIL unsigned_done_width[%0d] got %b want 0", i, da); end
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] av [4] = '{-64'sd100, 64'd100, 64'h8000_0000_0000_0000, -64'sd100};
      logic [W-1:0] bv [4] = '{64'd7, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFF, -64'sd7};
      logic [W-1:0] qe [4] = '{64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF2, 64'h8000_0000_0000_0000, 64'd14};
      logic [W-1:0] re [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
      int lat, sc; logic da;
      for (int i = 0; i < 4; i++) begin
         run_op(2'b01, av[i], bv[i], 0, lat, sc, da);
         checks++; if (quotient !== qe[i]) begin errors++; $display("FAIL signed_q[%0d] got %h want %h", i, quotient, qe[i]); end
         checks++; if (remainder !== re[i]) begin errors++; $display("FAIL signed_r[%0d] got %h want %h", i, remainder, re[i]); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL signed_dbz[%0d] got %b want 0", i, div_by_zero); end
         checks++; if (lat != 66) begin errors++; $display("FAIL signed_latency[%0d] got %0d want 66", i, lat); end
      end
   endtask

   task automatic test_div_by_zero();
      int lat, sc; logic da;
      for (int m = 0; m < 2; m++) begin
         run_op(2'(m), 64'h1234, 64'd0, 0, lat, sc, da);
         checks++; if (quotient !== '0) begin errors++; $display("FAIL dbz_q[m%0d] got %h want 0", m, quotient); end
         checks++; if (remainder !== 64'h1234) begin errors++; $display("FAIL dbz_r[m%0d] got %h want 1234", m, remainder); end
         checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag[m%0d] got %b want 1", m, div_by_zero); end
         checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency[m%0d] got %0d want 1", m, lat); end
         checks++; if (sc != 0) begin errors++; $display("FAIL dbz_stall[m%0d] got %0d want 0", m, sc); end
      end
      run_op(2'b00, 64'd9, 64'd4, 0, lat, sc, da);
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_cleared got %b want 0", div_by_zero); end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, qe, re; logic ze; logic [1:0] m;
      int lat, sc; logic da;
      for (int i = 0; i < 40; i++) begin
         m = 2'($urandom_range(0, 3));
         a = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 64'($urandom_range(1, 15));
            2: b = -64'($urandom_range(1, 15));
            3: b = {32'd0, $urandom};
            default: b = {$urandom, $urandom};
         endcase
         if (i % 10 == 3) a = 64'h8000_0000_0000_0000;
         ref_div(m, a, b, qe, re, ze);
         run_op(m, a, b, 0, lat, sc, da);
         checks++; if ({quotient, remainder, div_by_zero} !== {qe, re, ze})
            begin errors++; $display("FAIL random[%0d] m=%0d %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b", i, m, a, b, quotient, remainder, div_by_zero, qe, re, ze); end
         checks++; if (lat != (ze ? 1 : 66)) begin errors++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, ze ? 1 : 66); end
      end
   endtask

   task automatic test_restart_ignored();
      int lat, sc; logic da;
      run_op(2'b00, 64'd1000, 64'd3, 10, lat, sc, da);
      checks++; if (quotient !== 64'd333 || remainder !== 64'd1) begin errors++; $display("FAIL restart_result got q=%0d r=%0d want q=333 r=1", quotient, remainder); end
      checks++; if (lat != 66) begin errors++; $display("FAIL restart_latency got %0d want 66", lat); end
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL restart_idle got done=%b stall=%b want 0 0", done, stall); end
   endtask

   task automatic test_reset_mid_op();
      int lat, sc, seen; logic da;
      @(negedge clk);
      div_mode = 2'b00; dividend = 64'd500; divisor = 64'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if ({quotient, remainder} !== '0) begin errors++; $display("FAIL midreset_outputs got q=%h r=%h want 0 0", quotient, remainder); end
      checks++; if ({div_by_zero, done, stall} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b want 000", {div_by_zero, done, stall}); end
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", seen); end
      run_op(2'b00, 64'd100, 64'd7, 0, lat, sc, da);
      checks++; if (quotient !== 64'd14 || remainder !== 64'd2 || lat != 66) begin errors++; $display("FAIL midreset_recover got q=%0d r=%0d lat=%0d want 14 2 66", quotient, remainder, lat); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_restart_ignored();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_divider

`default_nettype wire
